// File: rtl/spi_ram_pkg.sv
// Shared types and widths for the SPI slave, its golden model and the command RAM.
//   RX_W    : width of a received SPI word ([9:8] command, [7:0] payload)
//   DATA_W  : byte width of the RAM and of the transmit path
//   cmd_e   : command encoding carried in rx_data[9:8]
//   proto_state_e : address-valid tracking for the command RAM
package spi_ram_pkg;

    localparam int unsigned RX_W   = 10;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CMD_W  = 2;

    typedef enum logic [CMD_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } cmd_e;

    // Which of the write/read pointers has been loaded since reset.
    typedef enum logic [1:0] {
        NO_ADDR  = 2'b00,
        WR_RDY   = 2'b01,
        RD_RDY   = 2'b10,
        BOTH_RDY = 2'b11
    } proto_state_e;

endpackage

// File: rtl/spram_core.sv
// Synchronous single-port RAM, one-cycle read latency, read-first on writes, no reset.
// Ports:
//   clk   : clock
//   en    : access enable; rdata only changes on enabled cycles
//   we    : write enable (with en)
//   addr  : word address
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
module spram_core #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Array and read register: read-first ordering falls out of the NBA semantics.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            if (we) begin
                mem_q[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_cmd_mem.sv
// Command-decoded RAM behind the SPI slave.
// Decodes rx_data[9:8] into address-set / write / read commands, tracks which
// pointers are valid, and presents read bytes to the slave on tx_data/tx_valid.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active-high (memory contents are kept)
//   rx_data   : [9:8] command, [7:0] payload; used only when rx_valid=1
//   rx_valid  : one-cycle strobe for rx_data
//   tx_data   : read byte, stable while tx_valid=1, zero after reset
//   tx_valid  : read byte available; held until the next non-read command
//   proto_err : one-cycle pulse after a data command with no address set
// Note: ADDR_SIZE must not exceed the 8-bit payload width.
module spi_ram_cmd_mem
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter bit          AUTO_INC  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RX_W-1:0]   rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              proto_err
);

    proto_state_e         state_q, state_d;
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 proto_err_q, proto_err_d;

    logic                 ram_en_c;
    logic                 ram_we_c;
    logic [ADDR_SIZE-1:0] ram_addr_c;
    logic [DATA_W-1:0]    ram_rdata;

    cmd_e                 cmd_c;
    logic [DATA_W-1:0]    payload_c;
    logic                 wr_vld_c;
    logic                 rd_vld_c;

    assign cmd_c     = cmd_e'(rx_data[RX_W-1 -: CMD_W]);
    assign payload_c = rx_data[DATA_W-1:0];
    assign wr_vld_c  = (state_q == WR_RDY) || (state_q == BOTH_RDY);
    assign rd_vld_c  = (state_q == RD_RDY) || (state_q == BOTH_RDY);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NO_ADDR;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_valid_q  <= tx_valid_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Command decode, protocol FSM and RAM port control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tx_valid_d  = tx_valid_q;
        proto_err_d = 1'b0;
        ram_en_c    = 1'b0;
        ram_we_c    = 1'b0;
        ram_addr_c  = rd_ptr_q;

        // Reset drops any coincident command, including its RAM access.
        if (rx_valid && !rst) begin
            // Any command except a successful read releases tx_valid.
            tx_valid_d = 1'b0;
            unique case (cmd_c)
                WR_ADDR: begin
                    wr_ptr_d = payload_c[ADDR_SIZE-1:0];
                    unique case (state_q)
                        NO_ADDR: state_d = WR_RDY;
                        RD_RDY:  state_d = BOTH_RDY;
                        default: state_d = state_q;
                    endcase
                end
                WR_DATA: begin
                    if (wr_vld_c) begin
                        ram_en_c   = 1'b1;
                        ram_we_c   = 1'b1;
                        ram_addr_c = wr_ptr_q;
                        if (AUTO_INC) begin
                            wr_ptr_d = wr_ptr_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                RD_ADDR: begin
                    rd_ptr_d = payload_c[ADDR_SIZE-1:0];
                    unique case (state_q)
                        NO_ADDR: state_d = RD_RDY;
                        WR_RDY:  state_d = BOTH_RDY;
                        default: state_d = state_q;
                    endcase
                end
                RD_DATA: begin
                    if (rd_vld_c) begin
                        ram_en_c   = 1'b1;
                        ram_addr_c = rd_ptr_q;
                        tx_valid_d = 1'b1;
                        if (AUTO_INC) begin
                            rd_ptr_d = rd_ptr_q + ADDR_SIZE'(1);
                        end
                    end else begin
                        proto_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    spram_core #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_SIZE),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .addr  (ram_addr_c),
        .wdata (payload_c),
        .rdata (ram_rdata)
    );

    // The RAM read register is the tx byte holder: it only moves on an enabled
    // access, and every access other than a successful read also clears
    // tx_valid, so the byte cannot change while it is being shifted out.
    // Gating with tx_valid gives the zero value after reset or a release.
    assign tx_data   = tx_valid_q ? ram_rdata : '0;
    assign tx_valid  = tx_valid_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_spi_ram_cmd_mem.sv
// Self-checking bench: directed scenarios plus randomized command traffic,
// checked against a behavioural model of the command RAM.
module tb_spi_ram_cmd_mem;

    logic       clk = 1'b0;
    logic [1:0] rst_v;
    logic [1:0] rx_valid_v;
    logic [9:0] rx_data_v [2];
    logic [7:0] tx_data_v [2];
    logic [1:0] tx_valid_v;
    logic [1:0] proto_err_v;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0: no auto-increment. Instance 1: auto-increment.
    spi_ram_cmd_mem #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) dut0 (
        .clk(clk), .rst(rst_v[0]), .rx_data(rx_data_v[0]), .rx_valid(rx_valid_v[0]),
        .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]), .proto_err(proto_err_v[0])
    );
    spi_ram_cmd_mem #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .rx_data(rx_data_v[1]), .rx_valid(rx_valid_v[1]),
        .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]), .proto_err(proto_err_v[1])
    );

    // Behavioural model: pointers, address-set flags, byte array with known mask.
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    int         m_wp [2];
    int         m_rp [2];
    bit         m_wv [2];
    bit         m_rv [2];
    bit         m_txv [2];
    bit         m_err [2];
    logic [7:0] m_txd [2];
    bit         m_txdk [2];
    bit         m_auto [2] = '{1'b0, 1'b1};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model(input int k, input bit r, input bit v, input logic [9:0] w);
        int p;
        p = int'(w[7:0]);
        if (r) begin
            m_wp[k] = 0;  m_rp[k] = 0;  m_wv[k] = 0;  m_rv[k] = 0;
            m_txv[k] = 0; m_err[k] = 0; m_txd[k] = 8'h00; m_txdk[k] = 1;
            return;
        end
        m_err[k] = 0;
        if (!v) return;
        if (w[9:8] == 2'd3 && m_rv[k]) begin
            m_txv[k]  = 1;
            m_txd[k]  = m_mem[k][m_rp[k]];
            m_txdk[k] = m_known[k][m_rp[k]];
            if (m_auto[k]) m_rp[k] = (m_rp[k] + 1) % 256;
            return;
        end
        m_txv[k]  = 0;
        m_txdk[k] = 0;
        case (w[9:8])
            2'd0: begin m_wp[k] = p; m_wv[k] = 1; end
            2'd1: begin
                if (m_wv[k]) begin
                    m_mem[k][m_wp[k]]   = w[7:0];
                    m_known[k][m_wp[k]] = 1;
                    if (m_auto[k]) m_wp[k] = (m_wp[k] + 1) % 256;
                end else begin
                    m_err[k] = 1;
                end
            end
            2'd2: begin m_rp[k] = p; m_rv[k] = 1; end
            default: m_err[k] = 1;
        endcase
    endtask

    task automatic check_model(input int k);
        chk($sformatf("dut%0d.tx_valid", k), 8'(tx_valid_v[k]), 8'(m_txv[k]));
        chk($sformatf("dut%0d.proto_err", k), 8'(proto_err_v[k]), 8'(m_err[k]));
        if (m_txdk[k]) chk($sformatf("dut%0d.tx_data", k), tx_data_v[k], m_txd[k]);
    endtask

    // One clock: drive instance k, leave the other idle, then check both.
    task automatic step(input int k, input bit r, input bit v, input logic [9:0] w);
        for (int i = 0; i < 2; i++) begin
            rst_v[i]      = (i == k) ? r : 1'b0;
            rx_valid_v[i] = (i == k) ? v : 1'b0;
            rx_data_v[i]  = (i == k) ? w : 10'h000;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) model(i, rst_v[i], rx_valid_v[i], rx_data_v[i]);
        rst_v      = 2'b00;
        rx_valid_v = 2'b00;
        for (int i = 0; i < 2; i++) check_model(i);
    endtask

    task automatic cmd(input int k, input logic [9:0] w);
        step(k, 1'b0, 1'b1, w);
    endtask

    task automatic idle(input int k);
        step(k, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic reset(input int k);
        step(k, 1'b1, 1'b0, 10'h000);
    endtask

    initial begin
        rst_v        = 2'b00;
        rx_valid_v   = 2'b00;
        rx_data_v[0] = 10'h000;
        rx_data_v[1] = 10'h000;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) begin
                m_mem[k][a]   = 8'h00;
                m_known[k][a] = 0;
            end
        end
        // Bring both instances out of reset.
        step(0, 1'b1, 1'b0, 10'h000);
        step(1, 1'b1, 1'b0, 10'h000);
        chk("rst.tx_valid", 8'(tx_valid_v[0]), 8'h00);
        chk("rst.tx_data", tx_data_v[0], 8'h00);
        chk("rst.proto_err", 8'(proto_err_v[0]), 8'h00);

        // 1: basic write then read; tx_valid held through idle, released by WR_ADDR.
        cmd(0, 10'h0A5);
        cmd(0, 10'h13C);
        cmd(0, 10'h2A5);
        cmd(0, 10'h300);
        chk("t1.tx_valid", 8'(tx_valid_v[0]), 8'h01);
        chk("t1.tx_data", tx_data_v[0], 8'h3C);
        for (int i = 0; i < 10; i++) begin
            idle(0);
            chk("t1.hold", 8'(tx_valid_v[0]), 8'h01);
        end
        cmd(0, 10'h000);
        chk("t1.release", 8'(tx_valid_v[0]), 8'h00);

        // 2: write without address flags an error and leaves mem[0] untouched.
        cmd(0, 10'h000);
        cmd(0, 10'h177);
        reset(0);
        cmd(0, 10'h1FF);
        chk("t2.err", 8'(proto_err_v[0]), 8'h01);
        idle(0);
        chk("t2.err_pulse", 8'(proto_err_v[0]), 8'h00);
        cmd(0, 10'h000);
        cmd(0, 10'h200);
        cmd(0, 10'h300);
        chk("t2.tx_data", tx_data_v[0], 8'h77);

        // 3: auto-increment with wrap at the top address.
        reset(1);
        cmd(1, 10'h0FF);
        cmd(1, 10'h111);
        cmd(1, 10'h122);
        cmd(1, 10'h2FF);
        cmd(1, 10'h300);
        chk("t3.rd0", tx_data_v[1], 8'h11);
        cmd(1, 10'h300);
        chk("t3.rd1", tx_data_v[1], 8'h22);
        chk("t3.tx_valid", 8'(tx_valid_v[1]), 8'h01);

        // 4: reset coincident with a read while tx_valid is high.
        step(1, 1'b1, 1'b1, 10'h300);
        chk("t4.tx_valid", 8'(tx_valid_v[1]), 8'h00);
        chk("t4.tx_data", tx_data_v[1], 8'h00);
        chk("t4.proto_err", 8'(proto_err_v[1]), 8'h00);
        cmd(1, 10'h300);
        chk("t4.err", 8'(proto_err_v[1]), 8'h01);

        // 5: memory survives reset.
        cmd(0, 10'h010);
        cmd(0, 10'h15A);
        reset(0);
        cmd(0, 10'h010);
        cmd(0, 10'h210);
        cmd(0, 10'h300);
        chk("t5.tx_data", tx_data_v[0], 8'h5A);

        // 6: fill both arrays, then random traffic with back-to-back strobes and resets.
        for (int a = 0; a < 256; a++) begin
            cmd(0, {2'b00, 8'(a)});
            cmd(0, {2'b01, 8'($urandom)});
        end
        cmd(1, 10'h000);
        for (int a = 0; a < 256; a++) cmd(1, {2'b01, 8'($urandom)});
        for (int n = 0; n < 3000; n++) begin
            step(n % 2, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 60, 10'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
